// File: rtl/alu_seq_pkg.sv
// Shared opcodes and FSM state type for the sequential ALU.
package alu_seq_pkg;

   localparam logic [3:0] OpAnd  = 4'b0000;
   localparam logic [3:0] OpOr   = 4'b0001;
   localparam logic [3:0] OpAdd  = 4'b0010;
   localparam logic [3:0] OpSub  = 4'b0110;
   localparam logic [3:0] OpSlt  = 4'b0111;
   localparam logic [3:0] OpNor  = 4'b1100;
   localparam logic [3:0] OpSltu = 4'b1000;
   localparam logic [3:0] OpMulu = 4'b0011;
   localparam logic [3:0] OpDivu = 4'b0101;
   localparam logic [3:0] OpRemu = 4'b1001;

   typedef enum logic [1:0] {
      StIdle,
      StMul,
      StDiv,
      StDone
   } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU: logic ops, add/sub, set-less-than, with carry/overflow flags.
module alu_core
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_control,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
);

   localparam int unsigned Msb = WIDTH - 1;

   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;

   assign sum  = {1'b0, a} + {1'b0, b};
   // Subtract as a + ~b + 1 so carry_out=1 means no borrow.
   assign diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

   always_comb begin
      result    = '0;
      carry_out = 1'b0;
      overflow  = 1'b0;
      case (alu_control)
         OpAnd: result = a & b;
         OpOr:  result = a | b;
         OpNor: result = ~(a | b);
         OpAdd: begin
            result    = sum[WIDTH-1:0];
            carry_out = sum[WIDTH];
            overflow  = (a[Msb] == b[Msb]) && (sum[Msb] != a[Msb]);
         end
         OpSub: begin
            result    = diff[WIDTH-1:0];
            carry_out = diff[WIDTH];
            overflow  = (a[Msb] != b[Msb]) && (diff[Msb] != a[Msb]);
         end
         OpSlt:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OpSltu: result = {{(WIDTH-1){1'b0}}, (a < b)};
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops via alu_core, iterative shift-add multiply and restoring divide.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_resultado,
   output logic             zero,
   output logic             carry_out,
   output logic             overflow
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [3:0]         op_q, op_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               zero_q, zero_d;
   logic               c_q, c_d;
   logic               v_q, v_d;

   logic [WIDTH-1:0]   core_res;
   logic               core_c;
   logic               core_v;

   logic               load;
   logic [WIDTH-1:0]   load_res;
   logic               load_c;
   logic               load_v;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     trial;
   logic [2*WIDTH-1:0] div_next;

   alu_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .a          (a),
      .b          (b),
      .alu_control(alu_control),
      .result     (core_res),
      .carry_out  (core_c),
      .overflow   (core_v)
   );

   // Multiply: acc = {high, multiplier}; add multiplicand into high half, then shift right.
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // Divide: acc = {remainder, quotient/dividend}; a negative trial keeps the old remainder.
   assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
   assign trial    = rem_sh - {1'b0, b_q};
   assign div_next = trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                  : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

   assign in_ready      = (state_q == StIdle) && !rst;
   assign out_valid     = (state_q == StDone);
   assign out_resultado = res_q;
   assign zero          = zero_q;
   assign carry_out     = c_q;
   assign overflow      = v_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      res_d    = res_q;
      zero_d   = zero_q;
      c_d      = c_q;
      v_d      = v_q;
      load     = 1'b0;
      load_res = '0;
      load_c   = 1'b0;
      load_v   = 1'b0;

      case (state_q)
         StIdle: begin
            if (in_valid && in_ready) begin
               a_d   = a;
               b_d   = b;
               op_d  = alu_control;
               cnt_d = '0;
               if (alu_control == OpMulu) begin
                  acc_d   = {{WIDTH{1'b0}}, b};
                  state_d = StMul;
               end else if ((alu_control == OpDivu || alu_control == OpRemu) && (b != '0)) begin
                  acc_d   = {{WIDTH{1'b0}}, a};
                  state_d = StDiv;
               end else begin
                  state_d = StDone;
                  load    = 1'b1;
                  if (alu_control == OpDivu) begin
                     load_res = '1;
                  end else if (alu_control == OpRemu) begin
                     load_res = a;
                  end else begin
                     load_res = core_res;
                     load_c   = core_c;
                     load_v   = core_v;
                  end
               end
            end
         end
         StMul: begin
            acc_d = mul_next;
            if (cnt_q == CntLast) begin
               cnt_d    = '0;
               state_d  = StDone;
               load     = 1'b1;
               load_res = mul_next[WIDTH-1:0];
               load_v   = |mul_next[2*WIDTH-1:WIDTH];
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDiv: begin
            acc_d = div_next;
            if (cnt_q == CntLast) begin
               cnt_d    = '0;
               state_d  = StDone;
               load     = 1'b1;
               load_res = (op_q == OpDivu) ? div_next[WIDTH-1:0] : div_next[2*WIDTH-1:WIDTH];
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (load) begin
         res_d  = load_res;
         zero_d = (load_res == '0);
         c_d    = load_c;
         v_d    = load_v;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         acc_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         c_q     <= c_d;
         v_q     <= v_d;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: 32-bit and 8-bit instances against an arithmetic reference model.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic        iv;
   logic        ordy;
   logic [31:0] a_s;
   logic [31:0] b_s;
   logic [3:0]  op_s;

   logic        ir32, ov32, z32, c32, v32;
   logic [31:0] res32;
   logic        ir8, ov8, z8, c8, v8;
   logic [7:0]  res8;

   logic        ir, ov, z, c, v;
   logic [31:0] res;

   int total = 0;
   int bad   = 0;

   logic [3:0] ops [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                            4'b1100, 4'b1000, 4'b0011, 4'b0101, 4'b1001};
   logic [3:0] bad_ops [6] = '{4'b0100, 4'b1010, 4'b1011, 4'b1101, 4'b1110, 4'b1111};

   alu_seq #(
      .WIDTH(32)
   ) u_dut32 (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (iv & ~sel),
      .in_ready     (ir32),
      .a            (a_s),
      .b            (b_s),
      .alu_control  (op_s),
      .out_valid    (ov32),
      .out_ready    (ordy & ~sel),
      .out_resultado(res32),
      .zero         (z32),
      .carry_out    (c32),
      .overflow     (v32)
   );

   alu_seq #(
      .WIDTH(8)
   ) u_dut8 (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (iv & sel),
      .in_ready     (ir8),
      .a            (a_s[7:0]),
      .b            (b_s[7:0]),
      .alu_control  (op_s),
      .out_valid    (ov8),
      .out_ready    (ordy & sel),
      .out_resultado(res8),
      .zero         (z8),
      .carry_out    (c8),
      .overflow     (v8)
   );

   assign ir  = sel ? ir8 : ir32;
   assign ov  = sel ? ov8 : ov32;
   assign z   = sel ? z8  : z32;
   assign c   = sel ? c8  : c32;
   assign v   = sel ? v8  : v32;
   assign res = sel ? {24'b0, res8} : res32;

   initial forever #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model written directly from the opcode rules with wide integer arithmetic.
   function automatic void model(input int w, input logic [3:0] op, input logic [63:0] xi,
                                 input logic [63:0] yi, output logic [63:0] r,
                                 output logic co, output logic vo);
      logic [63:0] mask, x, y, s, p;
      longint sx, sy;
      int m;
      mask = (64'd1 << w) - 64'd1;
      x = xi & mask;
      y = yi & mask;
      m = w - 1;
      r = '0;
      co = 1'b0;
      vo = 1'b0;
      case (op)
         4'b0000: r = x & y;
         4'b0001: r = x | y;
         4'b1100: r = ~(x | y) & mask;
         4'b0010: begin
            s = x + y;
            r = s & mask;
            co = s[w];
            vo = (x[m] == y[m]) && (r[m] != x[m]);
         end
         4'b0110: begin
            s = x + (~y & mask) + 64'd1;
            r = s & mask;
            co = s[w];
            vo = (x[m] != y[m]) && (r[m] != x[m]);
         end
         4'b0111: begin
            sx = x[m] ? longint'(x) - (longint'(1) << w) : longint'(x);
            sy = y[m] ? longint'(y) - (longint'(1) << w) : longint'(y);
            r = (sx < sy) ? 64'd1 : 64'd0;
         end
         4'b1000: r = (x < y) ? 64'd1 : 64'd0;
         4'b0011: begin
            p = x * y;
            r = p & mask;
            vo = (p >> w) != 64'd0;
         end
         4'b0101: r = (y == 0) ? mask : x / y;
         4'b1001: r = (y == 0) ? x : x % y;
         default: r = '0;
      endcase
   endfunction

   task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input string tag);
      logic [63:0] er, mask;
      logic ec, ev;
      int w, el, lat, g;
      w = sel ? 8 : 32;
      mask = (64'd1 << w) - 64'd1;
      model(w, op, {32'b0, x}, {32'b0, y}, er, ec, ev);
      el = (op == 4'b0011 || ((op == 4'b0101 || op == 4'b1001) && (({32'b0, y} & mask) != 0)))
           ? w + 1 : 1;
      @(negedge clk);
      g = 0;
      while (!ir && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (!ir) begin
         total++;
         bad++;
         $display("FAIL %s ready_timeout: in_ready got 0 want 1", tag);
         return;
      end
      a_s = x;
      b_s = y;
      op_s = op;
      iv = 1'b1;
      @(posedge clk);
      #1;
      iv = 1'b0;
      a_s = $urandom;
      b_s = $urandom;
      op_s = 4'($urandom);
      lat = 1;
      while (!ov && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      total++;
      if (lat !== el) begin
         bad++;
         $display("FAIL %s latency: got %0d want %0d", tag, lat, el);
      end
      total++;
      if (res !== er[31:0]) begin
         bad++;
         $display("FAIL %s result: got %h want %h", tag, res, er[31:0]);
      end
      total++;
      if (z !== (er == 64'd0)) begin
         bad++;
         $display("FAIL %s zero: got %b want %b", tag, z, (er == 64'd0));
      end
      total++;
      if (c !== ec) begin
         bad++;
         $display("FAIL %s carry: got %b want %b", tag, c, ec);
      end
      total++;
      if (v !== ev) begin
         bad++;
         $display("FAIL %s overflow: got %b want %b", tag, v, ev);
      end
      @(negedge clk);
      ordy = 1'b1;
      @(posedge clk);
      #1;
      ordy = 1'b0;
      total++;
      if (ov !== 1'b0 || ir !== 1'b1) begin
         bad++;
         $display("FAIL %s release: got valid=%b ready=%b want valid=0 ready=1", tag, ov, ir);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      iv = 1'b0;
      ordy = 1'b0;
      a_s = '0;
      b_s = '0;
      op_s = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         total++;
         if (ov !== 1'b0 || res !== 32'd0 || z !== 1'b0 || c !== 1'b0 || v !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs w%0d: got valid=%b res=%h z=%b c=%b v=%b want all 0",
                     sel ? 8 : 32, ov, res, z, c, v);
         end
         total++;
         if (ir !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready w%0d: got %b want 0", sel ? 8 : 32, ir);
         end
      end
      sel = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (ir !== 1'b1) begin
         bad++;
         $display("FAIL ready_after_reset: got %b want 1", ir);
      end
   endtask

   task automatic test_vectors32();
      sel = 1'b0;
      run_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, "add_ovf");
      run_op(4'b0011, 32'h0001_0000, 32'h0001_0000, "mulu_hi");
      run_op(4'b0101, 32'd100, 32'd7, "divu_100_7");
      run_op(4'b1001, 32'd100, 32'd7, "remu_100_7");
      run_op(4'b0101, 32'd5, 32'd0, "divu_by0");
      run_op(4'b1001, 32'd5, 32'd0, "remu_by0");
   endtask

   task automatic test_backpressure();
      sel = 1'b0;
      @(negedge clk);
      ordy = 1'b1;
      @(posedge clk);
      #1;
      ordy = 1'b0;
      total++;
      if (ov !== 1'b0 || ir !== 1'b1) begin
         bad++;
         $display("FAIL idle_out_ready: got valid=%b ready=%b want valid=0 ready=1", ov, ir);
      end
      @(negedge clk);
      a_s = 32'd20;
      b_s = 32'd30;
      op_s = 4'b0110;
      iv = 1'b1;
      @(posedge clk);
      #1;
      iv = 1'b0;
      for (int i = 0; i < 5; i++) begin
         total++;
         if (ov !== 1'b1 || res !== 32'hFFFF_FFF6 || c !== 1'b0 || ir !== 1'b0) begin
            bad++;
            $display("FAIL hold_%0d: got valid=%b res=%h c=%b ready=%b want 1 fffffff6 0 0",
                     i, ov, res, c, ir);
         end
         a_s = $urandom;
         b_s = $urandom;
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      ordy = 1'b1;
      @(posedge clk);
      #1;
      ordy = 1'b0;
      total++;
      if (ir !== 1'b1 || ov !== 1'b0) begin
         bad++;
         $display("FAIL hold_release: got ready=%b valid=%b want ready=1 valid=0", ir, ov);
      end
   endtask

   task automatic test_reset_abort();
      sel = 1'b0;
      @(negedge clk);
      a_s = 32'h1234_5678;
      b_s = 32'h0000_0FFF;
      op_s = 4'b0011;
      iv = 1'b1;
      @(posedge clk);
      #1;
      iv = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (ov !== 1'b0 || res !== 32'd0 || z !== 1'b0 || ir !== 1'b0) begin
         bad++;
         $display("FAIL abort: got valid=%b res=%h z=%b ready=%b want 0 0 0 0", ov, res, z, ir);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if (ir !== 1'b1) begin
         bad++;
         $display("FAIL abort_ready: got %b want 1", ir);
      end
      run_op(4'b0010, 32'd5, 32'd3, "add_after_abort");
      run_op(4'b0011, 32'hDEAD_BEEF, 32'h0000_1234, "mulu_after_abort");
   endtask

   task automatic test_back_to_back();
      sel = 1'b0;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (ir !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready_%0d: got %b want 1", i, ir);
         end
         run_op(ops[$urandom_range(0, 6)], $urandom, $urandom, "b2b");
      end
   endtask

   task automatic test_random(input int n);
      logic [3:0] op;
      logic [31:0] x, y;
      for (int i = 0; i < n; i++) begin
         op = ($urandom_range(0, 9) == 0) ? bad_ops[$urandom_range(0, 5)]
                                          : ops[$urandom_range(0, 9)];
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 3))
            0: ;
            1: begin
               x = 32'($urandom_range(0, 300));
               y = 32'($urandom_range(0, 20));
            end
            2: y = 32'd0;
            default: begin
               x = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
               y = $urandom_range(0, 1) ? 32'h8000_0000 : 32'hFFFF_FFFF;
            end
         endcase
         if (sel) begin
            x = x & 32'hFF;
            y = y & 32'hFF;
         end
         run_op(op, x, y, sel ? "rand8" : "rand32");
      end
   endtask

   task automatic test_width8();
      sel = 1'b1;
      run_op(4'b0111, 32'h80, 32'h01, "slt8");
      run_op(4'b1000, 32'h80, 32'h01, "sltu8");
      run_op(4'b0011, 32'h10, 32'h10, "mulu8");
      run_op(4'b1111, 32'h5A, 32'hA5, "badop8");
      test_random(20);
      sel = 1'b0;
   endtask

   initial begin
      sel = 1'b0;
      test_reset();
      test_vectors32();
      test_backpressure();
      test_reset_abort();
      test_back_to_back();
      test_random(30);
      test_width8();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
